// File: rtl/tc_sram_pkg.sv
// Shared helpers for the tc_sram functional memory model: default geometry,
// SimInit names, derived-width functions and default-sized word/address/byte-enable types.
package tc_sram_pkg;

  localparam int unsigned DefNumWords  = 1024;
  localparam int unsigned DefDataWidth = 128;
  localparam int unsigned DefByteWidth = 8;
  localparam int unsigned DefNumPorts  = 2;
  localparam int unsigned DefLatency   = 1;

  localparam string SimInitNone   = "none";
  localparam string SimInitZeros  = "zeros";
  localparam string SimInitOnes   = "ones";
  localparam string SimInitRandom = "random";

  function automatic int unsigned calc_addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  function automatic int unsigned calc_be_width(input int unsigned data_width,
                                                input int unsigned byte_width);
    return (data_width + byte_width - 1) / byte_width;
  endfunction

  typedef logic [calc_addr_width(DefNumWords)-1:0]                addr_t;
  typedef logic [DefDataWidth-1:0]                                data_t;
  typedef logic [calc_be_width(DefDataWidth, DefByteWidth)-1:0]   be_t;

endpackage

// File: rtl/tc_sram_rd_pipe.sv
// Per-port read-data pipeline, Latency stages deep; a stage loads only when the stage
// before it (or the read request, for stage 0) carried data, so idle cycles hold the output.
module tc_sram_rd_pipe
  import tc_sram_pkg::*;
#(
  parameter int unsigned Latency   = DefLatency,
  parameter int unsigned DataWidth = DefDataWidth
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ld,
  input  logic [DataWidth-1:0] i_dat,
  output logic [DataWidth-1:0] o_dat
);

  logic [Latency-1:0]                w_en;
  logic [Latency-1:0][DataWidth-1:0] r_dat;

  assign w_en[0] = i_ld;

  // Load strobes travel alongside the data so each read advances exactly one stage per cycle.
  if (Latency > 1) begin : g_vld
    logic [Latency-2:0] r_vld;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_vld <= '0;
      end else begin
        r_vld <= w_en[Latency-2:0];
      end
    end

    assign w_en[Latency-1:1] = r_vld;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dat <= '0;
    end else begin
      if (w_en[0]) begin
        r_dat[0] <= i_dat;
      end
      for (int s = 1; s < Latency; s++) begin
        if (w_en[s]) begin
          r_dat[s] <= r_dat[s-1];
        end
      end
    end
  end

  assign o_dat = r_dat[Latency-1];

endmodule

// File: rtl/tc_sram.sv
// Multi-port functional SRAM: writes commit at the edge (highest port wins per lane), reads are
// read-first with Latency cycles of pipeline (0 = combinational); no back-pressure, every request accepted.
module tc_sram
  import tc_sram_pkg::*;
#(
  parameter int unsigned NumWords    = DefNumWords,
  parameter int unsigned DataWidth   = DefDataWidth,
  parameter int unsigned ByteWidth   = DefByteWidth,
  parameter int unsigned NumPorts    = DefNumPorts,
  parameter int unsigned Latency     = DefLatency,
  parameter string       SimInit     = SimInitNone,
  parameter bit          PrintSimCfg = 1'b0,
  parameter int unsigned AddrWidth   = calc_addr_width(NumWords),
  parameter int unsigned BeWidth     = calc_be_width(DataWidth, ByteWidth)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  localparam bit InitZeros  = (SimInit == SimInitZeros);
  localparam bit InitOnes   = (SimInit == SimInitOnes);
  localparam bit InitRandom = (SimInit == SimInitRandom);
  localparam logic [AddrWidth:0] WordsExt = (AddrWidth+1)'(NumWords);

  if (NumPorts < 1) begin : g_err_ports
    $error("tc_sram: NumPorts must be >= 1");
  end
  if (NumWords < 1) begin : g_err_words
    $error("tc_sram: NumWords must be >= 1");
  end
  if (DataWidth < 1) begin : g_err_width
    $error("tc_sram: DataWidth must be >= 1");
  end
  if (ByteWidth < 1) begin : g_err_byte
    $error("tc_sram: ByteWidth must be >= 1");
  end
  if (PrintSimCfg) begin : g_print_cfg
    $info("tc_sram cfg: words=%0d width=%0d byte=%0d ports=%0d latency=%0d init=%s",
          NumWords, DataWidth, ByteWidth, NumPorts, Latency, SimInit);
  end

  logic [DataWidth-1:0]                r_mem [NumWords];
  logic [NumPorts-1:0]                 w_addr_ok;
  logic [NumPorts-1:0][DataWidth-1:0]  w_mask;
  logic [NumPorts-1:0][DataWidth-1:0]  w_rd_dat;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign w_addr_ok[p] = ({1'b0, addr_i[p]} < WordsExt);
    assign w_rd_dat[p]  = w_addr_ok[p] ? r_mem[addr_i[p]] : 'x;

    for (genvar i = 0; i < DataWidth; i++) begin : g_bit
      assign w_mask[p][i] = req_i[p] & we_i[p] & w_addr_ok[p] & be_i[p][i/ByteWidth];
    end

    if (Latency == 0) begin : g_comb
      assign rdata_o[p] = rst_i ? '0 : w_rd_dat[p];
    end else begin : g_pipe
      tc_sram_rd_pipe #(
        .Latency   (Latency),
        .DataWidth (DataWidth)
      ) u_rd_pipe (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_ld  (req_i[p] & ~we_i[p]),
        .i_dat (w_rd_dat[p]),
        .o_dat (rdata_o[p])
      );
    end

    a_rd_addr_range: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i[p] && !we_i[p]) |-> w_addr_ok[p])
      else $error("tc_sram: port %0d read address out of range", p);
  end

  // Later ports' non-blocking writes land after earlier ones, so the highest port wins each lane.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if (InitZeros || InitOnes) begin
        for (int unsigned w = 0; w < NumWords; w++) begin
          r_mem[w] <= InitOnes ? '1 : '0;
        end
      end else if (InitRandom) begin
        for (int unsigned w = 0; w < NumWords; w++) begin
          for (int unsigned i = 0; i < DataWidth; i++) begin
            r_mem[w][i] <= 1'($urandom);
          end
        end
      end
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        for (int unsigned i = 0; i < DataWidth; i++) begin
          if (w_mask[p][i]) begin
            r_mem[addr_i[p]][i] <= wdata_i[p][i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tc_sram.sv
// Bench for tc_sram: three instances (Latency 0, 1, 2) share one stimulus stream and are
// compared against a golden word array plus a queue of reads awaiting delivery.
module tb_tc_sram;

  localparam int NW  = 16;
  localparam int DW  = 32;
  localparam int NP  = 2;
  localparam int AW  = 4;
  localparam int BEW = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NP-1:0]           req;
  logic [NP-1:0]           we;
  logic [NP-1:0][AW-1:0]   addr;
  logic [NP-1:0][DW-1:0]   wdata;
  logic [NP-1:0][BEW-1:0]  be;
  logic [NP-1:0][DW-1:0]   rdata0;
  logic [NP-1:0][DW-1:0]   rdata1;
  logic [NP-1:0][DW-1:0]   rdata2;

  always #5 clk = ~clk;

  tc_sram #(.NumWords(NW), .DataWidth(DW), .ByteWidth(8), .NumPorts(NP), .Latency(0),
            .SimInit("zeros"), .PrintSimCfg(1'b0)) u_l0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata0));

  tc_sram #(.NumWords(NW), .DataWidth(DW), .ByteWidth(8), .NumPorts(NP), .Latency(1),
            .SimInit("zeros"), .PrintSimCfg(1'b0)) u_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata1));

  tc_sram #(.NumWords(NW), .DataWidth(DW), .ByteWidth(8), .NumPorts(NP), .Latency(2),
            .SimInit("zeros"), .PrintSimCfg(1'b0)) u_l2 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata2));

  typedef struct {
    int            port;
    int            lat;
    int            ready_at;
    logic [DW-1:0] val;
  } rd_t;

  int            n_chk = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [DW-1:0] gold [NW];
  logic [DW-1:0] exp1 [NP];
  logic [DW-1:0] exp2 [NP];
  rd_t           pend [$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BEW-1:0] b);
    req[p]   = r;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    be[p]    = b;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock: check combinational reads, capture read-first data, apply writes in port
  // order, then compare the pipelined outputs with whatever reads have become due.
  task automatic tick();
    rd_t keep [$];
    #1;
    for (int p = 0; p < NP; p++) begin
      if (req[p] && !we[p]) begin
        chk($sformatf("l0_rd_p%0d", p), rdata0[p], gold[addr[p]]);
        pend.push_back('{port: p, lat: 1, ready_at: cyc + 1, val: gold[addr[p]]});
        pend.push_back('{port: p, lat: 2, ready_at: cyc + 2, val: gold[addr[p]]});
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (req[p] && we[p]) begin
        for (int b = 0; b < BEW; b++) begin
          if (be[p][b]) gold[addr[p]][b*8 +: 8] = wdata[p][b*8 +: 8];
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    foreach (pend[i]) begin
      if (pend[i].ready_at <= cyc) begin
        if (pend[i].lat == 1) exp1[pend[i].port] = pend[i].val;
        else                  exp2[pend[i].port] = pend[i].val;
      end else begin
        keep.push_back(pend[i]);
      end
    end
    pend = keep;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("l1_out_p%0d", p), rdata1[p], exp1[p]);
      chk($sformatf("l2_out_p%0d", p), rdata2[p], exp2[p]);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    for (int w = 0; w < NW; w++) gold[w] = '0;
    for (int p = 0; p < NP; p++) begin
      exp1[p] = '0;
      exp2[p] = '0;
    end

    // A write and a read presented during reset must have no effect.
    drive(1, 1'b1, 1'b1, 4'd5, 32'hFFFF_FFFF, 4'hF);
    drive(0, 1'b1, 1'b0, 4'd5, '0, '0);
    @(negedge clk);
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rst_l0_p%0d", p), rdata0[p], '0);
      chk($sformatf("rst_l1_p%0d", p), rdata1[p], '0);
      chk($sformatf("rst_l2_p%0d", p), rdata2[p], '0);
    end
    idle_all();
    rst = 1'b0;

    drive(0, 1'b1, 1'b0, 4'd5, '0, '0);
    tick();
    chk("zero_init_rd", rdata1[0], 32'h0000_0000);

    drive(0, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
    tick();
    drive(0, 1'b1, 1'b0, 4'd3, '0, '0);
    tick();
    chk("wr_rd_lat1", rdata1[0], 32'hDEAD_BEEF);

    drive(0, 1'b1, 1'b1, 4'd4, 32'hFFFF_FFFF, 4'hF);
    tick();
    drive(0, 1'b1, 1'b1, 4'd4, 32'h0000_0000, 4'b0101);
    tick();
    drive(0, 1'b1, 1'b0, 4'd4, '0, '0);
    tick();
    chk("be_merge", rdata1[0], 32'hFF00_FF00);

    drive(0, 1'b1, 1'b1, 4'd7, 32'h1111_1111, 4'hF);
    drive(1, 1'b1, 1'b1, 4'd7, 32'h2222_2222, 4'hF);
    tick();
    idle_all();
    drive(0, 1'b1, 1'b0, 4'd7, '0, '0);
    tick();
    chk("wr_collide", rdata1[0], 32'h2222_2222);

    drive(0, 1'b1, 1'b1, 4'd9, 32'hA5A5_A5A5, 4'hF);
    tick();
    drive(0, 1'b1, 1'b0, 4'd9, '0, '0);
    drive(1, 1'b1, 1'b1, 4'd9, 32'h1234_5678, 4'hF);
    tick();
    chk("rd_first_old", rdata1[0], 32'hA5A5_A5A5);
    idle_all();
    drive(0, 1'b1, 1'b0, 4'd9, '0, '0);
    tick();
    chk("rd_after_wr", rdata1[0], 32'h1234_5678);

    idle_all();
    tick();
    chk("hold_idle", rdata1[0], 32'h1234_5678);
    drive(0, 1'b1, 1'b1, 4'd0, 32'h0BAD_F00D, 4'hF);
    tick();
    chk("hold_on_wr", rdata1[0], 32'h1234_5678);

    drive(0, 1'b1, 1'b0, 4'd3, '0, '0);
    tick();
    chk("lat2_not_yet", rdata2[0], 32'h1234_5678);
    idle_all();
    tick();
    chk("lat2_arrive", rdata2[0], 32'hDEAD_BEEF);

    // Random soak; odd iterations spread over all words, even ones crowd four words for collisions.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        drive(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, (n % 2) ? 15 : 3)), $urandom, 4'($urandom_range(0, 15)));
      end
      tick();
      idle_all();
      repeat ($urandom_range(0, 5)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
